ucode_mem_arb: RTL

//   Shares the uCode program RAM between two requesters: the CPU (port C: fetch, @, !)
//   and the host loader/debug port (port H: program download, memory inspection).
//   One access per clock, round-robin with an optional host lock for burst loading.
//   A starvation counter bounds how long a lock can hold off the CPU.

---
 rtl/ucode_mem_arb_pkg.sv | 22 ++
 rtl/ucode_ram.sv | 38 +++
 rtl/ucode_mem_arb.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/ucode_mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ucode_mem_arb_pkg
// Brief   : Shared defaults and port-select encoding for the uCode RAM arbiter
// Revision: 1.0 - initial release
// ============================================================================
package ucode_mem_arb_pkg;

  // Default geometry of the uCode program RAM
  localparam int c_DEF_DATA_SZ  = 16;
  localparam int c_DEF_ADDR_SZ  = 8;
  // Default bound on consecutive locked host grants while the CPU waits
  localparam int c_DEF_LOCK_MAX = 8;

  // Identifies a requester; also the encoding of the last-granted state
  typedef enum logic {
    PORT_C = 1'b0,
    PORT_H = 1'b1
  } port_e;

endpackage : ucode_mem_arb_pkg
`default_nettype wire

// File: rtl/ucode_ram.sv
`default_nettype none
// ============================================================================
// Module  : ucode_ram
// Brief   : Single-port inferred block RAM, one write or one registered read
//           per clock. Contents are not reset.
// Revision: 1.0 - initial release
// ============================================================================
module ucode_ram #(
  parameter int DATA_SZ = 16,
  parameter int ADDR_SZ = 8
) (
  input  logic               i_clk,
  input  logic               i_we,
  input  logic               i_re,
  input  logic [ADDR_SZ-1:0] i_addr,
  input  logic [DATA_SZ-1:0] i_wdata,
  output logic [DATA_SZ-1:0] o_rdata
);

  localparam int c_DEPTH = 1 << ADDR_SZ;

  logic [DATA_SZ-1:0] r_mem [c_DEPTH];
  logic [DATA_SZ-1:0] r_rdata;

  // Storage write and registered read; the read register only moves on a read
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
    if (i_re) begin
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule : ucode_ram
`default_nettype wire

// File: rtl/ucode_mem_arb.sv
`default_nettype none
// ============================================================================
// Module  : ucode_mem_arb
// Brief   : Round-robin arbiter sharing the uCode RAM between the CPU (C) and
//           the host loader (H), with a bounded host lock for burst loading.
// Revision: 1.0 - initial release
// ============================================================================
module ucode_mem_arb
  import ucode_mem_arb_pkg::*;
#(
  parameter int DATA_SZ  = c_DEF_DATA_SZ,
  parameter int ADDR_SZ  = c_DEF_ADDR_SZ,
  parameter int LOCK_MAX = c_DEF_LOCK_MAX
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_c_req,
  input  logic               i_c_wr,
  input  logic [ADDR_SZ-1:0] i_c_addr,
  input  logic [DATA_SZ-1:0] i_c_wdata,
  output logic               o_c_gnt,
  output logic [DATA_SZ-1:0] o_c_rdata,
  output logic               o_c_rvalid,
  input  logic               i_h_req,
  input  logic               i_h_lock,
  input  logic               i_h_wr,
  input  logic [ADDR_SZ-1:0] i_h_addr,
  input  logic [DATA_SZ-1:0] i_h_wdata,
  output logic               o_h_gnt,
  output logic [DATA_SZ-1:0] o_h_rdata,
  output logic               o_h_rvalid
);

  localparam int                c_LOCK_W     = $clog2(LOCK_MAX + 1);
  localparam logic [c_LOCK_W-1:0] c_LOCK_LIMIT = c_LOCK_W'(LOCK_MAX);

  port_e               r_last_gnt;
  port_e               w_last_gnt_nxt;
  logic [c_LOCK_W-1:0] r_lock_cnt;
  logic [c_LOCK_W-1:0] w_lock_cnt_nxt;
  logic                w_c_gnt;
  logic                w_h_gnt;

  logic                w_ram_we;
  logic                w_ram_re;
  logic [ADDR_SZ-1:0]  w_ram_addr;
  logic [DATA_SZ-1:0]  w_ram_wdata;
  logic [DATA_SZ-1:0]  w_ram_rdata;

  logic                r_c_rvalid;
  logic                r_h_rvalid;
  logic [DATA_SZ-1:0]  r_c_hold;
  logic [DATA_SZ-1:0]  r_h_hold;

  // Arbiter state: who was granted last, and the locked-grant counter
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_last_gnt <= PORT_H;
      r_lock_cnt <= '0;
    end else begin
      r_last_gnt <= w_last_gnt_nxt;
      r_lock_cnt <= w_lock_cnt_nxt;
    end
  end

  // Grant decision plus next arbiter state; grants are suppressed during reset
  always_comb begin
    w_c_gnt        = 1'b0;
    w_h_gnt        = 1'b0;
    w_last_gnt_nxt = r_last_gnt;
    w_lock_cnt_nxt = r_lock_cnt;
    if (!i_rst) begin
      if (i_c_req && !i_h_req) begin
        w_c_gnt = 1'b1;
      end else if (i_h_req && !i_c_req) begin
        w_h_gnt = 1'b1;
      end else if (i_c_req && i_h_req) begin
        // Starvation bound overrides the lock; otherwise lock extends H's turn
        if (r_lock_cnt == c_LOCK_LIMIT) begin
          w_c_gnt = 1'b1;
        end else if (i_h_lock && (r_last_gnt == PORT_H)) begin
          w_h_gnt = 1'b1;
        end else if (r_last_gnt == PORT_H) begin
          w_c_gnt = 1'b1;
        end else begin
          w_h_gnt = 1'b1;
        end
      end

      if (w_c_gnt) begin
        w_last_gnt_nxt = PORT_C;
      end else if (w_h_gnt) begin
        w_last_gnt_nxt = PORT_H;
      end

      // Lock counter only measures how long C has been held off by a lock
      if (w_c_gnt || !i_h_lock) begin
        w_lock_cnt_nxt = '0;
      end else if (w_h_gnt && i_c_req && (r_lock_cnt != c_LOCK_LIMIT)) begin
        w_lock_cnt_nxt = r_lock_cnt + 1'b1;
      end
    end
  end

  assign o_c_gnt = w_c_gnt;
  assign o_h_gnt = w_h_gnt;

  // The single granted access is steered onto the RAM port
  assign w_ram_we    = (w_c_gnt && i_c_wr) || (w_h_gnt && i_h_wr);
  assign w_ram_re    = (w_c_gnt && !i_c_wr) || (w_h_gnt && !i_h_wr);
  assign w_ram_addr  = w_h_gnt ? i_h_addr : i_c_addr;
  assign w_ram_wdata = w_h_gnt ? i_h_wdata : i_c_wdata;

  ucode_ram #(
    .DATA_SZ (DATA_SZ),
    .ADDR_SZ (ADDR_SZ)
  ) u_ram (
    .i_clk   (i_clk),
    .i_we    (w_ram_we),
    .i_re    (w_ram_re),
    .i_addr  (w_ram_addr),
    .i_wdata (w_ram_wdata),
    .o_rdata (w_ram_rdata)
  );

  // Read-valid pipeline: tags the RAM output with the port that issued the read
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_c_rvalid <= 1'b0;
      r_h_rvalid <= 1'b0;
    end else begin
      r_c_rvalid <= w_c_gnt && !i_c_wr;
      r_h_rvalid <= w_h_gnt && !i_h_wr;
    end
  end

  // Per-port capture so each port keeps its last result when the other reads
  always_ff @(posedge i_clk) begin
    if (r_c_rvalid) begin
      r_c_hold <= w_ram_rdata;
    end
    if (r_h_rvalid) begin
      r_h_hold <= w_ram_rdata;
    end
  end

  assign o_c_rvalid = r_c_rvalid;
  assign o_h_rvalid = r_h_rvalid;
  assign o_c_rdata  = r_c_rvalid ? w_ram_rdata : r_c_hold;
  assign o_h_rdata  = r_h_rvalid ? w_ram_rdata : r_h_hold;

endmodule : ucode_mem_arb
`default_nettype wire
